// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM states,
// frame geometry and the baud divider computation.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  // Clock cycles per serial bit; truncating division, no fractional correction.
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. o_data shows the head entry
// whenever o_empty is low. Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_data,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_d;
  logic                  full_q;
  logic                  empty_q;
  logic                  push_s;
  logic                  pop_s;

  // Qualify the requests and compute the next occupancy.
  always_comb begin
    push_s  = i_push & ~full_q;
    pop_s   = i_pop & ~empty_q;
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == CW'(0));
    end
  end

  // Storage array; contents are don't-care once pointers are reset.
  always_ff @(posedge i_clk) begin
    if (push_s) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_count = count_q;
  assign o_full  = full_q;
  assign o_empty = empty_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 transmitter: bytes written through i_wr/o_bsy are queued in a
// FIFO and serialized LSB first on o_tx with contiguous back-to-back frames.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLK_FREQ   = 48_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr,
  input  logic [7:0]            i_data,
  output logic                  o_bsy,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_idle,
  output logic                  o_tx
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e   state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic        tx_q;

  logic [7:0]  fifo_data_s;
  logic        fifo_empty_s;
  logic        baud_end_s;
  logic        pop_s;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_wr),
    .i_data  (i_data),
    .i_pop   (pop_s),
    .o_data  (fifo_data_s),
    .o_count (o_count),
    .o_full  (o_bsy),
    .o_empty (fifo_empty_s)
  );

  // Pop the head when idle, or at the end of a stop bit so frames abut.
  always_comb begin
    baud_end_s = (baud_q == CNT_LAST);
    pop_s      = ~fifo_empty_s &
                 ((state_q == ST_IDLE) | ((state_q == ST_STOP) & baud_end_s));
    o_idle     = (state_q == ST_IDLE) & fifo_empty_s;
  end

  // Frame sequencer: state, baud counter, bit index, shifter and line driver.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          baud_q <= '0;
          tx_q   <= 1'b1;
          if (!fifo_empty_s) begin
            shift_q <= fifo_data_s;
            tx_q    <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (baud_end_s) begin
            baud_q  <= '0;
            idx_q   <= 3'd0;
            tx_q    <= shift_q[0];
            state_q <= ST_DATA;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_end_s) begin
            baud_q <= '0;
            if (idx_q == LAST_BIT) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              idx_q   <= idx_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (baud_end_s) begin
            baud_q <= '0;
            if (!fifo_empty_s) begin
              shift_q <= fifo_data_s;
              tx_q    <= 1'b0;
              state_q <= ST_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        default: begin
          baud_q  <= '0;
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx = tx_q;

endmodule
